// File: rtl/bt_pkg.sv
// Shared opcodes and receiver state encoding for the Bluetooth command front end.
package bt_pkg;

    localparam logic [7:0] CMD_PREV     = 8'h01;
    localparam logic [7:0] CMD_NEXT     = 8'h02;
    localparam logic [7:0] CMD_VUP      = 8'h03;
    localparam logic [7:0] CMD_VDN      = 8'h04;
    localparam logic [7:0] CMD_JMP_BASE = 8'h05;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT
    } rx_state_e;

endpackage

// File: rtl/bt_uart_rx.sv
// 8N1 UART receiver: input synchroniser, oversampling tick divider and framing FSM.
module bt_uart_rx
    import bt_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UART_RXD,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       err_o
);

    localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_FULL  = OS_W'(OVERSAMPLE - 1);

    logic [1:0]       sync_q;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic             rx_s;
    rx_state_e        state_q;
    logic [OS_W-1:0]  scnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;

    assign rx_s = sync_q[1];
    assign tick = (div_q == DIV_LAST);

    // Two-flop synchroniser; resets to the idle-high line level so release never fakes a start.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], UART_RXD};
        end
    end

    // Free-running divider producing one sample tick per DIV clocks.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Framing FSM with registered byte, valid and error outputs; advances on sample ticks only.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= RX_IDLE;
            scnt_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            if (tick) begin
                case (state_q)
                    RX_IDLE: begin
                        if (!rx_s) begin
                            state_q <= RX_START;
                            scnt_q  <= '0;
                        end
                    end
                    RX_START: begin
                        if (scnt_q == OS_HALF) begin
                            scnt_q <= '0;
                            bit_q  <= '0;
                            if (!rx_s) begin
                                state_q <= RX_DATA;
                            end else begin
                                err_o   <= 1'b1;
                                state_q <= RX_IDLE;
                            end
                        end else begin
                            scnt_q <= scnt_q + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (scnt_q == OS_FULL) begin
                            scnt_q  <= '0;
                            shift_q <= {rx_s, shift_q[7:1]};
                            if (bit_q == 3'd7) begin
                                state_q <= RX_STOP;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end else begin
                            scnt_q <= scnt_q + 1'b1;
                        end
                    end
                    RX_STOP: begin
                        if (scnt_q == OS_FULL) begin
                            scnt_q <= '0;
                            if (rx_s) begin
                                data_o  <= shift_q;
                                valid_o <= 1'b1;
                                state_q <= RX_IDLE;
                            end else begin
                                err_o   <= 1'b1;
                                state_q <= RX_WAIT;
                            end
                        end else begin
                            scnt_q <= scnt_q + 1'b1;
                        end
                    end
                    RX_WAIT: begin
                        if (rx_s) begin
                            state_q <= RX_IDLE;
                        end
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/bt_cmd_decoder.sv
// Bluetooth remote-control front end: UART receive, command decode, track and volume state.
module bt_cmd_decoder
    import bt_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int N_TRACKS   = 7,
    parameter int VOL_LEVELS = 16,
    parameter int VOL_RESET  = 8,
    parameter int WRAP       = 1,
    localparam int TRACK_W   = (N_TRACKS > 1) ? $clog2(N_TRACKS) : 1,
    localparam int VOL_W     = (VOL_LEVELS > 1) ? $clog2(VOL_LEVELS) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               UART_RXD,
    input  logic               ADV,
    output logic [7:0]         RXD_DATA,
    output logic               RXD_VALID,
    output logic [TRACK_W-1:0] TRACK,
    output logic               TRACK_STB,
    output logic [VOL_W-1:0]   VOLUME,
    output logic               VOL_STB,
    output logic               ERR_STB
);

    localparam logic [TRACK_W:0] TR_LAST = (TRACK_W + 1)'(N_TRACKS - 1);
    localparam logic [VOL_W:0]   VL_LAST = (VOL_W + 1)'(VOL_LEVELS - 1);

    logic               rx_err;
    logic [TRACK_W-1:0] track_q, track_d;
    logic [VOL_W-1:0]   vol_q, vol_d;
    logic               tstb_q, tstb_d;
    logic               vstb_q, vstb_d;
    logic               err_q, err_d;
    logic [TRACK_W:0]   track_ext, trk_next, trk_prev;
    logic [VOL_W:0]     vol_ext;
    logic [8:0]         jmp_off;
    logic               is_jmp;
    logic               track_cmd;

    bt_uart_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_rx (
        .CLK      (CLK),
        .RST      (RST),
        .UART_RXD (UART_RXD),
        .data_o   (RXD_DATA),
        .valid_o  (RXD_VALID),
        .err_o    (rx_err)
    );

    // Decode the freshly received byte and arbitrate it against ADV; widened arithmetic avoids 2^W wrap.
    always_comb begin
        track_ext = {1'b0, track_q};
        vol_ext   = {1'b0, vol_q};

        if (track_ext == TR_LAST) begin
            trk_next = (WRAP != 0) ? '0 : track_ext;
        end else begin
            trk_next = track_ext + 1'b1;
        end

        if (track_ext == '0) begin
            trk_prev = (WRAP != 0) ? TR_LAST : '0;
        end else begin
            trk_prev = track_ext - 1'b1;
        end

        jmp_off = {1'b0, RXD_DATA} - {1'b0, CMD_JMP_BASE};
        is_jmp  = (RXD_DATA >= CMD_JMP_BASE) && (jmp_off < 9'(N_TRACKS));

        track_d   = track_q;
        vol_d     = vol_q;
        tstb_d    = 1'b0;
        vstb_d    = 1'b0;
        err_d     = rx_err;
        track_cmd = 1'b0;

        if (RXD_VALID) begin
            if (RXD_DATA == CMD_PREV) begin
                track_d   = TRACK_W'(trk_prev);
                tstb_d    = 1'b1;
                track_cmd = 1'b1;
            end else if (RXD_DATA == CMD_NEXT) begin
                track_d   = TRACK_W'(trk_next);
                tstb_d    = 1'b1;
                track_cmd = 1'b1;
            end else if (RXD_DATA == CMD_VUP) begin
                if (vol_ext != VL_LAST) begin
                    vol_d  = VOL_W'(vol_ext + 1'b1);
                    vstb_d = 1'b1;
                end
            end else if (RXD_DATA == CMD_VDN) begin
                if (vol_q != '0) begin
                    vol_d  = vol_q - 1'b1;
                    vstb_d = 1'b1;
                end
            end else if (is_jmp) begin
                track_d   = TRACK_W'(jmp_off);
                tstb_d    = 1'b1;
                track_cmd = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        // A same-cycle track command overrides the player's advance request.
        if (ADV && !track_cmd) begin
            track_d = TRACK_W'(trk_next);
            tstb_d  = 1'b1;
        end
    end

    // Track, volume and strobe registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            track_q <= '0;
            vol_q   <= VOL_W'(VOL_RESET);
            tstb_q  <= 1'b0;
            vstb_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            track_q <= track_d;
            vol_q   <= vol_d;
            tstb_q  <= tstb_d;
            vstb_q  <= vstb_d;
            err_q   <= err_d;
        end
    end

    assign TRACK     = track_q;
    assign TRACK_STB = tstb_q;
    assign VOLUME    = vol_q;
    assign VOL_STB   = vstb_q;
    assign ERR_STB   = err_q;

endmodule

// File: tb/tb_bt_cmd_decoder.sv
// Bench for bt_cmd_decoder: a wrapping and a saturating instance share one UART line.
module tb_bt_cmd_decoder;

    localparam int CLK_HZ = 307_200;   // DIV = 2 so a bit lasts 32 clocks
    localparam int NT     = 7;
    localparam int VL     = 16;
    localparam int VR     = 8;
    localparam int BITC   = 32;
    localparam int GAP    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxd = 1'b1;
    logic adv = 1'b0;

    logic [7:0] rdata [2];
    logic       rvalid[2];
    logic [2:0] trk   [2];
    logic       tstb  [2];
    logic [3:0] vol   [2];
    logic       vstb  [2];
    logic       estb  [2];

    always #5 clk = ~clk;

    bt_cmd_decoder #(.CLK_HZ(CLK_HZ), .BAUD(9600), .OVERSAMPLE(16), .N_TRACKS(NT),
                     .VOL_LEVELS(VL), .VOL_RESET(VR), .WRAP(1)) u_wrap (
        .CLK(clk), .RST(rst_n), .UART_RXD(rxd), .ADV(adv),
        .RXD_DATA(rdata[0]), .RXD_VALID(rvalid[0]), .TRACK(trk[0]), .TRACK_STB(tstb[0]),
        .VOLUME(vol[0]), .VOL_STB(vstb[0]), .ERR_STB(estb[0]));

    bt_cmd_decoder #(.CLK_HZ(CLK_HZ), .BAUD(9600), .OVERSAMPLE(16), .N_TRACKS(NT),
                     .VOL_LEVELS(VL), .VOL_RESET(VR), .WRAP(0)) u_sat (
        .CLK(clk), .RST(rst_n), .UART_RXD(rxd), .ADV(adv),
        .RXD_DATA(rdata[1]), .RXD_VALID(rvalid[1]), .TRACK(trk[1]), .TRACK_STB(tstb[1]),
        .VOLUME(vol[1]), .VOL_STB(vstb[1]), .ERR_STB(estb[1]));

    int chk = 0;
    int pass = 0;
    int cyc = 0;
    int n_valid[2], n_tstb[2], n_vstb[2], n_err[2];
    int last_valid[2], last_tstb[2];
    int n_wide = 0;
    logic [3:0] prev_s[2];
    int start_cyc;

    int m_trk[2];
    int m_vol;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe counters and pulse-width monitor
    initial begin
        for (int i = 0; i < 2; i++) begin
            n_valid[i] = 0; n_tstb[i] = 0; n_vstb[i] = 0; n_err[i] = 0;
            last_valid[i] = 0; last_tstb[i] = 0; prev_s[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rvalid[i]) begin n_valid[i]++; last_valid[i] = cyc; end
                if (tstb[i])   begin n_tstb[i]++;  last_tstb[i]  = cyc; end
                if (vstb[i])   n_vstb[i]++;
                if (estb[i])   n_err[i]++;
                if (({rvalid[i], tstb[i], vstb[i], estb[i]} & prev_s[i]) != 4'b0) n_wide++;
                prev_s[i] = {rvalid[i], tstb[i], vstb[i], estb[i]};
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int f_next(int t, bit w);
        if (w) return (t + 1) % NT;
        return (t + 1 > NT - 1) ? NT - 1 : t + 1;
    endfunction

    function automatic int f_prev(int t, bit w);
        if (w) return (t + NT - 1) % NT;
        return (t > 0) ? t - 1 : 0;
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit adv_hit,
                              output int e_t, output int e_v, output int e_e);
        bit tc;
        int bi;
        bi = int'(b);
        e_t = 0; e_v = 0; e_e = 0; tc = 1'b0;
        if (bi == 1) begin
            for (int i = 0; i < 2; i++) m_trk[i] = f_prev(m_trk[i], i == 0);
            e_t = 1; tc = 1'b1;
        end else if (bi == 2) begin
            for (int i = 0; i < 2; i++) m_trk[i] = f_next(m_trk[i], i == 0);
            e_t = 1; tc = 1'b1;
        end else if (bi == 3) begin
            if (m_vol < VL - 1) begin m_vol++; e_v = 1; end
        end else if (bi == 4) begin
            if (m_vol > 0) begin m_vol--; e_v = 1; end
        end else if (bi >= 5 && bi - 5 < NT) begin
            for (int i = 0; i < 2; i++) m_trk[i] = bi - 5;
            e_t = 1; tc = 1'b1;
        end else begin
            e_e = 1;
        end
        if (adv_hit && !tc) begin
            for (int i = 0; i < 2; i++) m_trk[i] = f_next(m_trk[i], i == 0);
            e_t = 1;
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_hi, input int hold_low);
        start_cyc = cyc;
        rxd = 1'b0;
        step(BITC);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            step(BITC);
        end
        rxd = stop_hi;
        step(BITC);
        if (hold_low > 0) begin
            rxd = 1'b0;
            step(hold_low);
        end
        rxd = 1'b1;
        step(GAP);
    endtask

    // Sends a byte and pulses ADV in the cycle its RXD_VALID is high; returns 1 if aligned.
    task automatic send_with_adv(input logic [7:0] b, output bit hit);
        hit = 1'b0;
        fork
            send_byte(b, 1'b1, 0);
            begin
                for (int i = 0; i < 400 && !hit; i++) begin
                    @(negedge clk);
                    if (rvalid[0]) begin
                        hit = 1'b1;
                        adv = 1'b1;
                        @(negedge clk);
                        adv = 1'b0;
                    end
                end
            end
        join
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        step(5);
        for (int i = 0; i < 2; i++) begin
            chk++;
            if ({rdata[i], trk[i], vol[i], rvalid[i], tstb[i], vstb[i], estb[i]} !==
                {8'h00, 3'd0, 4'(VR), 4'b0000})
                $display("FAIL reset[%0d]: got data=%h trk=%0d vol=%0d stb=%b%b%b%b, want 00/0/%0d/0000",
                         i, rdata[i], trk[i], vol[i], rvalid[i], tstb[i], vstb[i], estb[i], VR);
            else pass++;
        end
        m_trk[0] = 0; m_trk[1] = 0; m_vol = VR;
        rst_n = 1'b1;
        step(5);
    endtask

    task automatic test_next_x3;
        int et, ev, ee, dv;
        for (int n = 1; n <= 3; n++) begin
            send_byte(8'h02, 1'b1, 0);
            model_byte(8'h02, 1'b0, et, ev, ee);
            dv = last_valid[0] - start_cyc;
            for (int i = 0; i < 2; i++) begin
                chk++;
                if (trk[i] !== 3'(n)) $display("FAIL next_x3 track[%0d]: got %0d want %0d", i, trk[i], n);
                else pass++;
                chk++;
                if (last_tstb[i] !== last_valid[i] + 1)
                    $display("FAIL next_x3 stb_latency[%0d]: got %0d want %0d", i, last_tstb[i] - last_valid[i], 1);
                else pass++;
            end
            chk++;
            if (dv < 300 || dv > 316) $display("FAIL next_x3 valid_timing: got %0d want 300..316", dv);
            else pass++;
        end
        chk++;
        if (rdata[0] !== 8'h02) $display("FAIL next_x3 rxd_data: got %h want 02", rdata[0]);
        else pass++;
        chk++;
        if (n_tstb[0] !== 3) $display("FAIL next_x3 stb_count: got %0d want 3", n_tstb[0]);
        else pass++;
    endtask

    task automatic test_wrap_sat;
        int et, ev, ee, t0;
        send_byte(8'h05, 1'b1, 0); model_byte(8'h05, 1'b0, et, ev, ee);
        t0 = n_tstb[1];
        send_byte(8'h01, 1'b1, 0); model_byte(8'h01, 1'b0, et, ev, ee);
        chk++;
        if (trk[0] !== 3'd6) $display("FAIL wrap prev_at_0: got %0d want 6", trk[0]); else pass++;
        chk++;
        if (trk[1] !== 3'd0) $display("FAIL sat prev_at_0: got %0d want 0", trk[1]); else pass++;
        chk++;
        if (n_tstb[1] !== t0 + 1) $display("FAIL sat prev_stb: got %0d want %0d", n_tstb[1] - t0, 1); else pass++;
        send_byte(8'h0B, 1'b1, 0); model_byte(8'h0B, 1'b0, et, ev, ee);
        t0 = n_tstb[1];
        send_byte(8'h02, 1'b1, 0); model_byte(8'h02, 1'b0, et, ev, ee);
        chk++;
        if (trk[0] !== 3'd0) $display("FAIL wrap next_at_6: got %0d want 0", trk[0]); else pass++;
        chk++;
        if (trk[1] !== 3'd6) $display("FAIL sat next_at_6: got %0d want 6", trk[1]); else pass++;
        chk++;
        if (n_tstb[1] !== t0 + 1) $display("FAIL sat next_stb: got %0d want %0d", n_tstb[1] - t0, 1); else pass++;
    endtask

    task automatic test_volume;
        int et, ev, ee, v0;
        v0 = n_vstb[0];
        for (int n = 0; n < 10; n++) begin
            send_byte(8'h03, 1'b1, 0); model_byte(8'h03, 1'b0, et, ev, ee);
        end
        chk++;
        if (vol[0] !== 4'd15) $display("FAIL vol_up sat: got %0d want 15", vol[0]); else pass++;
        chk++;
        if (n_vstb[0] - v0 !== 7) $display("FAIL vol_up stb: got %0d want 7", n_vstb[0] - v0); else pass++;
        v0 = n_vstb[0];
        for (int n = 0; n < 20; n++) begin
            send_byte(8'h04, 1'b1, 0); model_byte(8'h04, 1'b0, et, ev, ee);
        end
        chk++;
        if (vol[1] !== 4'd0) $display("FAIL vol_dn sat: got %0d want 0", vol[1]); else pass++;
        chk++;
        if (n_vstb[1] - v0 !== 15) $display("FAIL vol_dn stb: got %0d want 15", n_vstb[1] - v0); else pass++;
    endtask

    task automatic test_jump_err;
        int et, ev, ee, e0, v0;
        send_byte(8'h09, 1'b1, 0); model_byte(8'h09, 1'b0, et, ev, ee);
        chk++;
        if (trk[0] !== 3'd4) $display("FAIL jump 0x09: got %0d want 4", trk[0]); else pass++;
        e0 = n_err[0]; v0 = n_valid[0];
        send_byte(8'h0C, 1'b1, 0); model_byte(8'h0C, 1'b0, et, ev, ee);
        send_byte(8'h55, 1'b1, 0); model_byte(8'h55, 1'b0, et, ev, ee);
        chk++;
        if (n_err[0] - e0 !== 2) $display("FAIL unknown err_count: got %0d want 2", n_err[0] - e0); else pass++;
        chk++;
        if (n_valid[0] - v0 !== 2) $display("FAIL unknown valid_count: got %0d want 2", n_valid[0] - v0); else pass++;
        chk++;
        if (trk[1] !== 3'd4) $display("FAIL unknown track: got %0d want 4", trk[1]); else pass++;
    endtask

    task automatic test_line_errors;
        int et, ev, ee, e0, v0, t0;
        e0 = n_err[0]; v0 = n_valid[0]; t0 = n_tstb[0];
        send_byte(8'h02, 1'b0, 3 * 10 * BITC);
        chk++;
        if (n_err[0] - e0 !== 1) $display("FAIL stop_low err_count: got %0d want 1", n_err[0] - e0); else pass++;
        chk++;
        if (n_valid[0] - v0 !== 0) $display("FAIL stop_low valid_count: got %0d want 0", n_valid[0] - v0); else pass++;
        e0 = n_err[0];
        rxd = 1'b0; step(BITC / 4); rxd = 1'b1; step(2 * BITC);
        chk++;
        if (n_err[0] - e0 !== 1) $display("FAIL glitch err_count: got %0d want 1", n_err[0] - e0); else pass++;
        chk++;
        if ({n_valid[0] - v0, n_tstb[0] - t0} !== {32'd0, 32'd0})
            $display("FAIL glitch activity: got valid+%0d tstb+%0d want 0/0", n_valid[0] - v0, n_tstb[0] - t0);
        else pass++;
        send_byte(8'h02, 1'b1, 0); model_byte(8'h02, 1'b0, et, ev, ee);
        for (int i = 0; i < 2; i++) begin
            chk++;
            if (trk[i] !== 3'(m_trk[i])) $display("FAIL recover track[%0d]: got %0d want %0d", i, trk[i], m_trk[i]);
            else pass++;
        end
    endtask

    task automatic test_adv;
        int et, ev, ee, t0;
        bit hit;
        adv = 1'b1; step(1); adv = 1'b0; step(3);
        for (int i = 0; i < 2; i++) m_trk[i] = f_next(m_trk[i], i == 0);
        for (int i = 0; i < 2; i++) begin
            chk++;
            if (trk[i] !== 3'(m_trk[i])) $display("FAIL adv_idle track[%0d]: got %0d want %0d", i, trk[i], m_trk[i]);
            else pass++;
        end
        t0 = n_tstb[0];
        send_with_adv(8'h07, hit); model_byte(8'h07, hit, et, ev, ee);
        chk++;
        if (!hit) $display("FAIL adv_jump alignment: got timeout want RXD_VALID"); else pass++;
        chk++;
        if (trk[0] !== 3'd2 || trk[1] !== 3'd2) $display("FAIL adv_jump track: got %0d/%0d want 2/2", trk[0], trk[1]);
        else pass++;
        chk++;
        if (n_tstb[0] - t0 !== 1) $display("FAIL adv_jump stb: got %0d want 1", n_tstb[0] - t0); else pass++;
        send_with_adv(8'h03, hit); model_byte(8'h03, hit, et, ev, ee);
        chk++;
        if ({trk[0], vol[0]} !== {3'(m_trk[0]), 4'(m_vol)})
            $display("FAIL adv_vol: got trk=%0d vol=%0d want trk=%0d vol=%0d", trk[0], vol[0], m_trk[0], m_vol);
        else pass++;
    endtask

    task automatic test_reset_midbyte;
        int et, ev, ee;
        rxd = 1'b0; step(BITC); rxd = 1'b1; step(2 * BITC); rxd = 1'b0; step(BITC / 2);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk++;
            if ({rdata[i], trk[i], vol[i], rvalid[i], tstb[i], vstb[i], estb[i]} !==
                {8'h00, 3'd0, 4'(VR), 4'b0000})
                $display("FAIL midbyte_reset[%0d]: got data=%h trk=%0d vol=%0d", i, rdata[i], trk[i], vol[i]);
            else pass++;
        end
        m_trk[0] = 0; m_trk[1] = 0; m_vol = VR;
        rxd = 1'b1; step(3); rst_n = 1'b1; step(2 * BITC);
        send_byte(8'h0A, 1'b1, 0); model_byte(8'h0A, 1'b0, et, ev, ee);
        chk++;
        if ({rdata[0], trk[0], vol[0]} !== {8'h0A, 3'd5, 4'(VR)})
            $display("FAIL after_reset byte: got data=%h trk=%0d vol=%0d want 0a/5/%0d", rdata[0], trk[0], vol[0], VR);
        else pass++;
    endtask

    task automatic test_random;
        int et, ev, ee, xt[2], xv[2], xe[2], r;
        int t0[2], v0[2], e0[2];
        logic [7:0] b;
        bit hit, want_adv;
        for (int i = 0; i < 2; i++) begin
            xt[i] = 0; xv[i] = 0; xe[i] = 0;
            t0[i] = n_tstb[i]; v0[i] = n_vstb[i]; e0[i] = n_err[i];
        end
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1: b = 8'h01;
                2, 3: b = 8'h02;
                4: b = 8'h03;
                5: b = 8'h04;
                6, 7: b = 8'(5 + $urandom_range(0, NT - 1));
                8: b = 8'(12 + $urandom_range(0, 243));
                default: b = 8'h00;
            endcase
            want_adv = ($urandom_range(0, 3) == 0);
            if (want_adv) send_with_adv(b, hit);
            else begin send_byte(b, 1'b1, 0); hit = 1'b0; end
            model_byte(b, hit, et, ev, ee);
            for (int i = 0; i < 2; i++) begin
                xt[i] += et; xv[i] += ev; xe[i] += ee;
                chk++;
                if ({trk[i], vol[i]} !== {3'(m_trk[i]), 4'(m_vol)})
                    $display("FAIL random[%0d] byte %h inst %0d: got trk=%0d vol=%0d want trk=%0d vol=%0d",
                             n, b, i, trk[i], vol[i], m_trk[i], m_vol);
                else pass++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk++;
            if ({n_tstb[i] - t0[i], n_vstb[i] - v0[i], n_err[i] - e0[i]} !== {xt[i], xv[i], xe[i]})
                $display("FAIL random strobe_counts[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         n_tstb[i] - t0[i], n_vstb[i] - v0[i], n_err[i] - e0[i], xt[i], xv[i], xe[i]);
            else pass++;
        end
    endtask

    task automatic test_strobe_width;
        chk++;
        if (n_wide !== 0) $display("FAIL strobe_width: got %0d multi-cycle strobes want 0", n_wide);
        else pass++;
    endtask

    initial begin
        test_reset();
        test_next_x3();
        test_wrap_sat();
        test_volume();
        test_jump_err();
        test_line_errors();
        test_adv();
        test_reset_midbyte();
        test_random();
        test_strobe_width();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
